// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants and FSM encoding for the UART transmit feeder.
package uart_tx_feeder_pkg;

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        S_SYNC      = 2'd0,
        S_IDLE      = 2'd1,
        S_WAIT_ACT  = 2'd2,
        S_WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// CPU write port plus uart_tx launch handshake of the transmit feeder.
interface uart_tx_feeder_if #(
    parameter int unsigned DEPTH = 16
);
    import uart_tx_feeder_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic              i_Wr_En;
    logic [BYTE_W-1:0] i_Wr_Data;
    logic              o_Full;
    logic              o_Empty;
    logic [AW:0]       o_Count;
    logic              o_Tx_DV;
    logic [BYTE_W-1:0] o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
    logic              o_Busy;
    logic              o_Overflow;
    logic              i_Ovf_Clr;

    modport slave (
        input  i_Wr_En, i_Wr_Data, i_Tx_Active, i_Tx_Done, i_Ovf_Clr,
        output o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Busy, o_Overflow
    );

    modport master (
        output i_Wr_En, i_Wr_Data, i_Tx_Active, i_Tx_Done, i_Ovf_Clr,
        input  o_Full, o_Empty, o_Count, o_Tx_DV, o_Tx_Byte, o_Busy, o_Overflow
    );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty; DEPTH must be a power of two.
module uart_tx_feeder_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok_c, pop_ok_c;

    // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
    always_comb begin
        pop_ok_c  = pop && !empty_q;
        push_ok_c = push && (!full_q || pop_ok_c);
        wr_d      = wr_q + PW'(push_ok_c);
        rd_d      = rd_q + PW'(pop_ok_c);
        cnt_d     = wr_d - rd_d;
        full_d    = (cnt_d == PW'(DEPTH));
        empty_d   = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

    assign head_c = mem_q[rd_q[AW-1:0]];
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = cnt_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of uart_tx, launching one queued byte per frame.
// Optional sticky overflow flag enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    uart_tx_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    feeder_state_e     state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              pop_c;
    logic [BYTE_W-1:0] head_c;
    logic              fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;

    uart_tx_feeder_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk    (i_Clock),
        .rst_n  (i_Rst_n),
        .push   (bus.i_Wr_En),
        .wdata  (bus.i_Wr_Data),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // S_SYNC gates every launch until the transmitter shows neither Active nor Done.
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop_c     = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (!bus.i_Tx_Active && !bus.i_Tx_Done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!fifo_empty) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = head_c;
                    pop_c     = 1'b1;
                    state_d   = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (bus.i_Tx_Active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.i_Tx_Done) state_d = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
        busy_d = !fifo_empty || (state_q == S_WAIT_ACT) || (state_q == S_WAIT_DONE)
                 || bus.i_Tx_Active;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q   <= S_SYNC;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    logic ovf_q, ovf_d;

    // A dropped write takes priority over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.i_Ovf_Clr) ovf_d = 1'b0;
        if (bus.i_Wr_En && fifo_full && !pop_c) ovf_d = 1'b1;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign bus.o_Overflow = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.i_Ovf_Clr;
    assign bus.o_Overflow = 1'b0;
`endif

    assign bus.o_Tx_DV   = tx_dv_q;
    assign bus.o_Tx_Byte = tx_byte_q;
    assign bus.o_Busy    = busy_q;
    assign bus.o_Full    = fifo_full;
    assign bus.o_Empty   = fifo_empty;
    assign bus.o_Count   = fifo_count;

endmodule
